// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds width defaults, the P0/P1 priority encoding and the x0 address.
package rf_wr_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int X0_ADDR    = 0;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } prio_t;

endpackage

// File: rtl/rf_arb_prio.sv
// Two-requester priority arbiter with aging of the load/multi-cycle port.
// req1 gains priority after WAIT_LIMIT consecutive lost conflicts.
module rf_arb_prio
  import rf_wr_arbiter_pkg::*;
#(
  parameter int WAIT_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output prio_t      state
);

  localparam logic [2:0] WL3 = WAIT_LIMIT[2:0];

  logic [2:0] wait_cnt;
  logic       lose1;

  always_comb begin
    grant = 2'b00;
    if (rst && !stall) begin
      unique case (1'b1)
        (valid == 2'b11):
          grant = (state == P1) ? 2'b10 : 2'b01;
        (valid == 2'b01):
          grant = 2'b01;
        (valid == 2'b10):
          grant = 2'b10;
        default:
          grant = 2'b00;
      endcase
    end
  end

  // grant is all-zero under stall, so state and count freeze there
  assign lose1 = grant[0] & valid[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= P0;
      wait_cnt <= 3'd0;
    end else if (grant[1]) begin
      state    <= P0;
      wait_cnt <= 3'd0;
    end else if (lose1) begin
      wait_cnt <= wait_cnt + 3'd1;
      if (wait_cnt + 3'd1 == WL3)
        state <= P1;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter with registered write outputs.
// Optional write-to-read forwarding is enabled by macro RF_ARB_FWD_EN.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WAIT_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              grant_id,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(X0_ADDR);

  logic [1:0] grant;
  prio_t      state_unused;

  rf_arb_prio #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .valid ({req1_valid, req0_valid}),
    .grant (grant),
    .state (state_unused)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      grant_id <= 1'b0;
    end else begin
      unique case (1'b1)
        grant[0]: begin
          WE3      <= (req0_addr != X0);
          A3       <= req0_addr;
          WD3      <= req0_data;
          grant_id <= 1'b0;
        end
        grant[1]: begin
          WE3      <= (req1_addr != X0);
          A3       <= req1_addr;
          WD3      <= req1_data;
          grant_id <= 1'b1;
        end
        default:
          WE3 <= 1'b0;
      endcase
    end
  end

`ifdef RF_ARB_FWD_EN
  assign rd1_out =
    (WE3 && (A3 == ra1) && (ra1 != X0)) ? WD3 : rf_rd1;
  assign rd2_out =
    (WE3 && (A3 == ra2) && (ra2 != X0)) ? WD3 : rf_rd2;
`else
  logic ra_unused;
  assign ra_unused = ^{ra1, ra2};
  assign rd1_out   = rf_rd1;
  assign rd2_out   = rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed + random bench for rf_wr_arbiter against a behavioural model.
module tb_rf_wr_arbiter;

  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        req0_ready, req1_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        grant_id;
  logic [4:0]  ra1, ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] rd1_out, rd2_out;

  int          n_cmp = 0;
  int          n_err = 0;

  int          lost;
  logic        g0, g1;
  logic        ewe, egid;
  logic [4:0]  ea;
  logic [31:0] ed;

  logic        nv0, nv1;
  logic [4:0]  na0, na1;
  logic [31:0] nd0, nd1;
  logic [7:0]  pat;

  always #5 clk = ~clk;

  rf_wr_arbiter #(
    .ADDR_W     (5),
    .DATA_W     (32),
    .WAIT_LIMIT (WL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req0_valid (v0),
    .req0_addr  (a0),
    .req0_data  (d0),
    .req0_ready (req0_ready),
    .req1_valid (v1),
    .req1_addr  (a1),
    .req1_data  (d1),
    .req1_ready (req1_ready),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .grant_id   (grant_id),
    .ra1        (ra1),
    .ra2        (ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .rd1_out    (rd1_out),
    .rd2_out    (rd2_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] ra,
                                      input logic [31:0] rf);
`ifdef RF_ARB_FWD_EN
    return (ewe && ea == ra && ra != 5'd0) ? ed : rf;
`else
    return rf;
`endif
  endfunction

  task automatic model_reset();
    lost = 0;
    ewe  = 1'b0;
    ea   = 5'd0;
    ed   = 32'd0;
    egid = 1'b0;
  endtask

  task automatic check_out();
    chk("we3", WE3, ewe);
    chk("a3", A3, ea);
    chk("wd3", WD3, ed);
    chk("grant_id", grant_id, egid);
    chk("wait_cnt", dut.u_prio.wait_cnt, lost);
    chk("state", dut.u_prio.state, lost >= WL);
    chk("rd1", rd1_out, fwd(ra1, rf_rd1));
    chk("rd2", rd2_out, fwd(ra2, rf_rd2));
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input logic iv0, input logic [4:0] ia0,
                      input logic [31:0] id0,
                      input logic iv1, input logic [4:0] ia1,
                      input logic [31:0] id1, input logic ist);
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    stall = ist;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst && !stall) begin
      if (v0 && v1) begin
        if (lost >= WL) g1 = 1'b1;
        else            g0 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1)     g1 = 1'b1;
    end
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    if (g1)            lost = 0;
    else if (g0 && v1) lost++;
    if (g0)      {ewe, ea, ed, egid} = {a0 != 5'd0, a0, d0, 1'b0};
    else if (g1) {ewe, ea, ed, egid} = {a1 != 5'd0, a1, d1, 1'b1};
    else         ewe = 1'b0;
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    ra1 = 0; ra2 = 0; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    g0 = 0; g1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // single req0 write, then idle
    step(1, 5'd4, 32'h71, 0, 5'd0, 32'h0, 0);
    chk("r17_we", WE3, 1'b1);
    chk("r17_a3", A3, 5'd4);
    chk("r17_wd", WD3, 32'h71);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    chk("r17_we_off", WE3, 1'b0);

    // continuous conflict: grants 0,0,0,1,0,0,0,1
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      step(1, 5'd2, 32'h100 + i, 1, 5'd3, 32'h200 + i, 0);
      chk($sformatf("r18_g%0d", i), grant_id, pat[i]);
    end

    // x0 write from req1 is suppressed
    step(0, 5'd0, 32'h0, 1, 5'd0, 32'h24, 0);
    chk("r19_we", WE3, 1'b0);
    chk("r19_a3", A3, 5'd0);

    // stall freezes aging, then resumes
    step(1, 5'd6, 32'h61, 1, 5'd7, 32'h71, 0);
    step(1, 5'd6, 32'h62, 1, 5'd7, 32'h71, 0);
    for (int i = 0; i < 3; i++)
      step(1, 5'd6, 32'h63, 1, 5'd7, 32'h71, 1);
    chk("r20_cnt", dut.u_prio.wait_cnt, 3'd2);
    step(1, 5'd6, 32'h63, 1, 5'd7, 32'h71, 0);
    chk("r20_resume", grant_id, 1'b0);
    step(1, 5'd6, 32'h64, 1, 5'd7, 32'h71, 0);
    chk("r20_age", grant_id, 1'b1);

    // forwarding to read port 1
    ra1 = 5'd8; rf_rd1 = 32'h0;
    step(1, 5'd8, 32'h72, 0, 5'd0, 32'h0, 0);
`ifdef RF_ARB_FWD_EN
    chk("r21_fwd", rd1_out, 32'h72);
`else
    chk("r21_fwd", rd1_out, 32'h0);
`endif
    ra1 = 5'd0; rf_rd1 = 32'h55;
    #1;
    chk("r21_x0", rd1_out, 32'h55);

    // reset mid-cycle with a pending req1-priority grant
    for (int i = 0; i < 3; i++)
      step(1, 5'd9, 32'h90 + i, 1, 5'd10, 32'hA0, 0);
    chk("r22_pre_we", WE3, 1'b1);
    v0 = 1; v1 = 1;
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    chk("r22_we", WE3, 1'b0);
    chk("r22_a3", A3, 5'd0);
    chk("r22_rdy", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b1;
    step(1, 5'd11, 32'hB0, 1, 5'd12, 32'hC0, 0);
    chk("r22_first", grant_id, 1'b0);

    // random traffic with held requests
    for (int i = 0; i < 400; i++) begin
      if (g0 || !v0) begin
        nv0 = ($urandom % 3) != 0;
        na0 = 5'($urandom % 8);
        nd0 = $urandom;
      end else begin
        nv0 = v0; na0 = a0; nd0 = d0;
      end
      if (g1 || !v1) begin
        nv1 = ($urandom % 3) != 0;
        na1 = 5'($urandom % 8);
        nd1 = $urandom;
      end else begin
        nv1 = v1; na1 = a1; nd1 = d1;
      end
      ra1    = 5'($urandom % 8);
      ra2    = 5'($urandom % 8);
      rf_rd1 = $urandom;
      rf_rd2 = $urandom;
      step(nv0, na0, nd0, nv1, na1, nd1, ($urandom % 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- WAIT_LIMIT, 3, consecutive lost conflicts before req1 gets priority; legal range 1..7.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-low reset.
- stall, in, 1, pipeline hold; blocks all grants.
- req0_valid, in, 1, writeback request from execute path.
- req0_addr, in, ADDR_W, destination register.
- req0_data, in, DATA_W, write data.
- req0_ready, out, 1, request 0 accepted this cycle.
- req1_valid, in, 1, writeback request from load/multi-cycle path.
- req1_addr, in, ADDR_W, destination register.
- req1_data, in, DATA_W, write data.
- req1_ready, out, 1, request 1 accepted this cycle.
- WE3, out, 1, register_file write enable (registered).
- A3, out, ADDR_W, register_file write address (registered).
- WD3, out, DATA_W, register_file write data (registered).
- grant_id, out, 1, requester that produced the current WE3/A3/WD3.
- ra1, in, ADDR_W, register_file read address 1 (mirrors A1).
- ra2, in, ADDR_W, register_file read address 2 (mirrors A2).
- rf_rd1, in, DATA_W, register_file RD1.
- rf_rd2, in, DATA_W, register_file RD2.
- rd1_out, out, DATA_W, read data 1 to datapath.
- rd2_out, out, DATA_W, read data 2 to datapath.

Function
REQ-003 Requester SHALL hold valid, addr and data stable until its ready is high; ready SHALL be combinational from valid, stall and arbiter state.
REQ-004 At most one ready SHALL be high per cycle; with stall=1 both readys SHALL be 0.
REQ-005 A handshake in cycle N SHALL drive WE3/A3/WD3/grant_id in cycle N+1 only (one-cycle pulse); with no handshake in N, WE3 SHALL be 0 in N+1 and A3/WD3 SHALL hold.
REQ-006 A handshake with addr==0 SHALL be accepted but produce WE3=0 (x0 write suppression); A3/WD3 still update.
REQ-007 FSM states SHALL be P0 (req0 wins conflicts) and P1 (req1 wins conflicts); a single valid requester SHALL be granted in either state.
REQ-008 wait_cnt (3 bits) SHALL increment when req1 loses a conflict and clear when req1 is granted.
REQ-009 P0->P1 SHALL occur when req1 loses and wait_cnt+1 == WAIT_LIMIT; P1->P0 SHALL occur on the req1 grant; stall SHALL freeze state and wait_cnt.
REQ-010 Grants to different requesters with equal addresses in consecutive cycles SHALL commit in grant order (later write wins).

Reset
REQ-011 While rst=0: WE3=0, A3=0, WD3=0, grant_id=0, state=P0, wait_cnt=0, both readys 0; takes effect immediately, independent of clk.
REQ-012 A handshake in the cycle reset asserts SHALL be discarded (no write after release); first grant possible in the first cycle with rst=1.

Configuration
REQ-013 Macro RF_ARB_FWD_EN defined: rdX_out SHALL equal WD3 when WE3=1, A3==raX and raX!=0, else rf_rdX (write-to-read forwarding).
REQ-014 RF_ARB_FWD_EN undefined: rdX_out SHALL equal rf_rdX; port list SHALL be identical in both builds.

Structure
REQ-015 Shared package SHALL hold ADDR_W/DATA_W defaults, the P0/P1 state encoding and the x0 address constant.
REQ-016 Priority/aging logic SHALL be a sub-module rf_arb_prio (inputs valids, stall; outputs grant vector, state); datapath registers and forwarding stay in the top.

Verification
REQ-017 req0 only, addr=4, data=0x71 in cycle N -> req0_ready=1 in N; WE3=1, A3=4, WD3=0x71, grant_id=0 in N+1; WE3=0 in N+2.
REQ-018 Both valid continuously, WAIT_LIMIT=3 -> grants 0,0,0,1,0,0,0,1; wait_cnt returns to 0 after each req1 grant.
REQ-019 req1 addr=0, data=0x24 -> req1_ready=1, WE3 stays 0, A3=0.
REQ-020 stall=1 for 3 cycles with both valid -> no readys, WE3=0, state and wait_cnt unchanged; grants resume on the cycle stall falls.
REQ-021 With RF_ARB_FWD_EN: write A3=8, WD3=0x72 while ra1=8, rf_rd1=0 -> rd1_out=0x72; same with ra1=0 -> rd1_out=rf_rd1. Without macro -> rd1_out=rf_rd1 in both cases.
REQ-022 rst driven low between clock edges during a pending grant -> WE3=0 immediately, no write after release, first post-reset grant goes to req0 on conflict.
